uart_parity_unit: RTL and testbench

//   Parametrised UART parity generator (TX) plus serial parity checker (RX).

---
 rtl/uart_parity_unit.sv | 173 +++++++++++++++++
 tb/tb_uart_parity_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_unit.sv
// UART parity unit: TX parity generator pipelined to the serializer load, and an
// RX parity checker that follows the deserializer's start/sample strobes and keeps
// sticky and saturating-count error status.
module uart_parity_unit #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PAR_EN,
    input  logic [1:0]               PAR_TYPE,
    input  logic [DATA_WIDTH-1:0]    TX_DATA,
    input  logic                     TX_tick,
    output logic                     par_bit,
    input  logic                     RX_start,
    input  logic                     RX_SAMPLE,
    input  logic                     RX_IN,
    input  logic                     ERR_CLR,
    output logic                     rx_busy,
    output logic                     rx_done,
    output logic                     par_err,
    output logic                     par_err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAR
    } rx_state_e;

    // Parity configuration frozen for the duration of one received frame.
    typedef struct packed {
        logic       en;
        logic [1:0] ptype;
    } rx_cfg_t;

    // Parity bit for a given type, from the XOR of the data bits.
    function automatic logic par_f(input logic [1:0] ptype, input logic xor_bits);
        case (ptype)
            2'b00:   return xor_bits;
            2'b01:   return ~xor_bits;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                     par_bit_q, par_bit_d;
    rx_state_e                state_q, state_d;
    logic                     acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    rx_cfg_t                  cfg_q, cfg_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     sticky_q, sticky_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     mismatch;

    // TX: capture the new word and emit parity of the previously captured word.
    always_comb begin
        // NOTE: every combinational output is given a default first so no path leaves it unassigned (no latch).
        tx_data_d = tx_data_q;
        par_bit_d = par_bit_q;
        if (TX_tick) begin
            tx_data_d = TX_DATA;
            par_bit_d = PAR_EN ? par_f(PAR_TYPE, ^tx_data_q) : 1'b1;
        end
    end

    // TX state register; par_bit idles at the stop level.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: state uses non-blocking assignments so all registers update together at the edge.
        if (!RST) begin
            tx_data_q <= '0;
            par_bit_q <= 1'b1;
        end else begin
            tx_data_q <= tx_data_d;
            par_bit_q <= par_bit_d;
        end
    end

    // RX next-state: start always restarts the frame, samples advance it, errors beat clears.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sticky_d  = sticky_q;
        err_cnt_d = err_cnt_q;
        mismatch  = 1'b0;

        if (ERR_CLR) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
        end

        if (RX_start) begin
            state_d   = ST_DATA;
            acc_d     = 1'b0;
            cnt_d     = '0;
            cfg_d.en    = PAR_EN;
            cfg_d.ptype = PAR_TYPE;
        end else if (RX_SAMPLE) begin
            case (state_q)
                ST_DATA: begin
                    acc_d = acc_q ^ RX_IN;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        if (cfg_q.en) begin
                            state_d = ST_PAR;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    mismatch = (RX_IN != par_f(cfg_q.ptype, acc_q));
                end
                default: ;
            endcase
        end

        if (mismatch) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
            if (ERR_CLR) begin
                err_cnt_d = ERR_CNT_WIDTH'(1);
            end else if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    // RX state register; reset discards any frame in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            cfg_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign par_bit        = par_bit_q;
    assign rx_busy        = (state_q != ST_IDLE);
    assign rx_done        = done_q;
    assign par_err        = err_q;
    assign par_err_sticky = sticky_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_unit.sv
// Directed bench for uart_parity_unit: three instances (8-bit, 7-bit, 2-bit error
// counter) share one stimulus stream; RX results of the 8-bit instance go through
// a scoreboard queue filled when each frame is driven.
module tb_uart_parity_unit;

    logic       CLK;
    logic       RST;
    logic       PAR_EN;
    logic [1:0] PAR_TYPE;
    logic [7:0] TX_DATA;
    logic       TX_tick;
    logic       RX_start;
    logic       RX_SAMPLE;
    logic       RX_IN;
    logic       ERR_CLR;

    logic       a_par_bit, a_busy, a_done, a_err, a_sticky;
    logic [7:0] a_err_cnt;
    logic       b_par_bit, b_busy, b_done, b_err, b_sticky;
    logic [7:0] b_err_cnt;
    logic       c_par_bit, c_busy, c_done, c_err, c_sticky;
    logic [1:0] c_err_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q[$];
    bit   sb_en = 0;
    logic sb_exp;
    logic [7:0] tx_prev = 8'h00;

    uart_parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) u_a (
        .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE),
        .TX_DATA(TX_DATA), .TX_tick(TX_tick), .par_bit(a_par_bit),
        .RX_start(RX_start), .RX_SAMPLE(RX_SAMPLE), .RX_IN(RX_IN), .ERR_CLR(ERR_CLR),
        .rx_busy(a_busy), .rx_done(a_done), .par_err(a_err),
        .par_err_sticky(a_sticky), .err_cnt(a_err_cnt)
    );

    uart_parity_unit #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(8)) u_b (
        .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE),
        .TX_DATA(TX_DATA[6:0]), .TX_tick(TX_tick), .par_bit(b_par_bit),
        .RX_start(RX_start), .RX_SAMPLE(RX_SAMPLE), .RX_IN(RX_IN), .ERR_CLR(ERR_CLR),
        .rx_busy(b_busy), .rx_done(b_done), .par_err(b_err),
        .par_err_sticky(b_sticky), .err_cnt(b_err_cnt)
    );

    uart_parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u_c (
        .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE),
        .TX_DATA(TX_DATA), .TX_tick(TX_tick), .par_bit(c_par_bit),
        .RX_start(RX_start), .RX_SAMPLE(RX_SAMPLE), .RX_IN(RX_IN), .ERR_CLR(ERR_CLR),
        .rx_busy(c_busy), .rx_done(c_done), .par_err(c_err),
        .par_err_sticky(c_sticky), .err_cnt(c_err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected parity bit for a type, given XOR of the data bits.
    function automatic logic exp_par(input logic [1:0] t, input logic x);
        case (t)
            2'b00:   return x;
            2'b01:   return ~x;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx_done of the 8-bit instance consumes one expected par_err.
    always @(negedge CLK) begin
        if (sb_en && a_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_par_err", {31'd0, a_err}, {31'd0, sb_exp});
            end
        end
        if (a_err === 1'b1 && a_done !== 1'b1)
            check("par_err_without_done", {31'd0, a_done}, 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cyc(2);
        RST = 1'b1;
        cyc(1);
    endtask

    task automatic tx(input logic [7:0] d, input string tag);
        logic e;
        e = PAR_EN ? exp_par(PAR_TYPE, ^tx_prev) : 1'b1;
        TX_DATA = d;
        TX_tick = 1'b1;
        cyc(1);
        TX_tick = 1'b0;
        tx_prev = d;
        check(tag, {31'd0, a_par_bit}, {31'd0, e});
    endtask

    task automatic sample(input logic b);
        RX_SAMPLE = 1'b1;
        RX_IN     = b;
        cyc(1);
        RX_SAMPLE = 1'b0;
    endtask

    task automatic start(input logic with_sample);
        RX_start  = 1'b1;
        RX_SAMPLE = with_sample;
        RX_IN     = 1'b1;
        cyc(1);
        RX_start  = 1'b0;
        RX_SAMPLE = 1'b0;
    endtask

    // Full 8-bit frame with parity; expectation pushed before the frame is driven.
    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic clr_on_par, input logic start_with_sample);
        exp_q.push_back(PAR_EN && (pbit != exp_par(PAR_TYPE, ^d)));
        start(start_with_sample);
        for (int i = 0; i < 8; i++) sample(d[i]);
        ERR_CLR = clr_on_par;
        sample(pbit);
        ERR_CLR = 1'b0;
        cyc(1);
    endtask

    initial begin
        RST = 1'b0; PAR_EN = 1'b0; PAR_TYPE = 2'b00; TX_DATA = 8'h00; TX_tick = 1'b0;
        RX_start = 1'b0; RX_SAMPLE = 1'b0; RX_IN = 1'b0; ERR_CLR = 1'b0;
        cyc(2);
        check("rst_par_bit", {31'd0, a_par_bit}, 32'd1);
        check("rst_busy",    {31'd0, a_busy},    32'd0);
        check("rst_done",    {31'd0, a_done},    32'd0);
        check("rst_err",     {31'd0, a_err},     32'd0);
        check("rst_sticky",  {31'd0, a_sticky},  32'd0);
        check("rst_err_cnt", {24'd0, a_err_cnt}, 32'd0);
        RST = 1'b1;
        cyc(1);

        // TX even parity, one-tick pipeline
        PAR_EN = 1'b1; PAR_TYPE = 2'b00;
        tx(8'hA5, "tx_even_first");
        tx(8'h00, "tx_even_a5");
        check("tx_even_a5_const", {31'd0, a_par_bit}, 32'd0);
        tx(8'h01, "tx_even_00");
        TX_DATA = 8'hFE;
        cyc(3);
        check("tx_hold", {31'd0, a_par_bit}, 32'd0);
        tx(8'hFF, "tx_even_01");
        check("tx_even_01_const", {31'd0, a_par_bit}, 32'd1);
        tx(8'h03, "tx_even_ff");
        // odd / mark / space / disabled with 8'h03 in the pipeline
        PAR_TYPE = 2'b01; tx(8'h03, "tx_odd_03");
        check("tx_odd_03_const", {31'd0, a_par_bit}, 32'd1);
        PAR_TYPE = 2'b10; tx(8'h03, "tx_mark");
        PAR_TYPE = 2'b11; tx(8'h03, "tx_space");
        check("tx_space_const", {31'd0, a_par_bit}, 32'd0);
        PAR_EN = 1'b0;    tx(8'h03, "tx_disabled");

        // RX even: good frame, bad frame; samples in IDLE are ignored
        do_reset();
        sb_en = 1'b1;
        PAR_EN = 1'b1; PAR_TYPE = 2'b00;
        sample(1'b1); sample(1'b0);
        check("idle_sample_busy", {31'd0, a_busy}, 32'd0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check("rx_good_sticky",  {31'd0, a_sticky},  32'd0);
        check("rx_good_err_cnt", {24'd0, a_err_cnt}, 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("rx_bad_sticky",  {31'd0, a_sticky},  32'd1);
        check("rx_bad_err_cnt", {24'd0, a_err_cnt}, 32'd1);
        PAR_TYPE = 2'b01; send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        PAR_TYPE = 2'b10; send_frame(8'h13, 1'b0, 1'b0, 1'b0);
        PAR_TYPE = 2'b11; send_frame(8'h13, 1'b0, 1'b0, 1'b0);
        check("rx_mix_err_cnt", {24'd0, a_err_cnt}, 32'd2);

        // 7-bit instance, parity off latched at start despite a later change
        do_reset();
        sb_en = 1'b0;
        PAR_EN = 1'b0; PAR_TYPE = 2'b00;
        start(1'b0);
        PAR_EN = 1'b1;
        for (int i = 0; i < 6; i++) sample(1'b1);
        check("w7_busy_mid", {31'd0, b_busy}, 32'd1);
        check("w7_done_mid", {31'd0, b_done}, 32'd0);
        sample(1'b1);
        check("w7_done_7th", {31'd0, b_done}, 32'd1);
        check("w7_idle_7th", {31'd0, b_busy}, 32'd0);
        check("w7_err_7th",  {31'd0, b_err},  32'd0);
        sample(1'b0);
        check("w7_8th_ignored_done", {31'd0, b_done}, 32'd0);
        check("w7_8th_ignored_busy", {31'd0, b_busy}, 32'd0);
        check("w8_cfg_latched_done", {31'd0, a_done}, 32'd1);
        cyc(2);

        // Abort then clean frame (start and sample together: sample discarded)
        do_reset();
        sb_en = 1'b1;
        PAR_EN = 1'b1; PAR_TYPE = 2'b00;
        start(1'b0);
        for (int i = 0; i < 4; i++) sample(1'b1);
        check("abort_busy", {31'd0, a_busy}, 32'd1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("abort_sticky", {31'd0, a_sticky}, 32'd0);
        check("abort_sb_drained", exp_q.size(), 32'd0);
        // Async reset mid-frame
        start(1'b0);
        sample(1'b1); sample(1'b0); sample(1'b1);
        check("rst_mid_busy_before", {31'd0, a_busy}, 32'd1);
        RST = 1'b0;
        #2;
        check("rst_mid_busy", {31'd0, a_busy}, 32'd0);
        check("rst_mid_done", {31'd0, a_done}, 32'd0);
        cyc(1);
        RST = 1'b1;
        cyc(1);

        // Saturating 2-bit counter, then clear colliding with a mismatch
        do_reset();
        PAR_EN = 1'b1; PAR_TYPE = 2'b00;
        for (int i = 0; i < 5; i++) send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        check("sat_c_err_cnt", {30'd0, c_err_cnt}, 32'd3);
        check("sat_a_err_cnt", {24'd0, a_err_cnt}, 32'd5);
        check("sat_c_sticky",  {31'd0, c_sticky},  32'd1);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
        check("clr_tie_c_err_cnt", {30'd0, c_err_cnt}, 32'd1);
        check("clr_tie_a_err_cnt", {24'd0, a_err_cnt}, 32'd1);
        check("clr_tie_sticky",    {31'd0, c_sticky},  32'd1);
        ERR_CLR = 1'b1;
        cyc(1);
        ERR_CLR = 1'b0;
        check("clr_err_cnt", {30'd0, c_err_cnt}, 32'd0);
        check("clr_sticky",  {31'd0, c_sticky},  32'd0);

        cyc(2);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
